mdu_ctrl: RTL
=============

MDU_CTRL -- requirements
Module: mdu_ctrl

Interface
REQ-001 SHALL have port: clk  input  1  single clock; all state on rising edge.
REQ-002 SHALL have port: reset  input  1  asynchronous, active-low; 0 clears all state immediately.
REQ-003 SHALL have port: E_MDop  input  4  E-stage multiply/divide opcode from the shared package.
REQ-004 SHALL have port: E_rs  input  32  forwarded rs operand.
REQ-005 SHALL have port: E_rt  input  32  forwarded rt operand.
REQ-006 SHALL have port: D_isMD  input  1  D-stage instruction uses the MDU (any non-NONE op).
REQ-007 SHALL have port: start  output  1  E-stage mult/div accepted this cycle.
REQ-008 SHALL have port: busy  output  1  operation in progress.
REQ-009 SHALL have port: stall  output  1  stall request to the D/E pipeline registers.
REQ-010 SHALL have port: E_HILOout  output  32  mfhi/mflo read data, carried into the M register.
REQ-011 SHALL have ports: HI and LO  outputs  32 each  architectural HI/LO registers.

Function
REQ-012 SHALL decode opcodes NONE=0, MULT=1, MULTU=2, DIV=3, DIVU=4, MFHI=5, MFLO=6, MTHI=7, MTLO=8, MADD=9, MADDU=10; values 11-15 are treated as NONE.
REQ-013 SHALL drive start=1 combinationally when E_MDop is MULT/MULTU/DIV/DIVU (or MADD/MADDU, see Configuration) and busy=0.
REQ-014 SHALL, on a start edge, latch E_rs, E_rt and the op, load the counter with 5 for multiply ops or 10 for divide ops, and set busy=1.
REQ-015 SHALL decrement the counter each cycle while busy; on the edge at which the counter equals 1, it SHALL write HI/LO and clear busy.
REQ-016 SHALL give a multiply started in cycle T busy=1 during T+1..T+5 and new HI/LO visible in T+6; a divide SHALL give busy during T+1..T+10 and HI/LO in T+11.
REQ-017 SHALL compute MULT as the signed 64-bit product and MULTU as the unsigned product, with {HI,LO}=product.
REQ-018 SHALL compute DIV/DIVU as LO=quotient and HI=remainder (signed: remainder takes the dividend sign); a zero divisor SHALL leave HI/LO unchanged but still take 10 cycles busy.
REQ-019 SHALL write MTHI/MTLO to HI/LO from E_rs at the next edge when busy=0, with no busy period.
REQ-020 SHALL drive E_HILOout=HI for MFHI, LO for MFLO, and 0 otherwise, combinationally from the current registers.
REQ-021 SHALL drive stall = D_isMD & (start | busy).
REQ-022 SHALL ignore any E_MDop presented while busy=1 (no restart, no HI/LO write).
REQ-023 SHALL NOT let the completing write and an E-stage MTHI/MTLO in the same cycle both occur; the MT op is stalled by REQ-021, so only the completion write takes effect.

Reset
REQ-024 SHALL on reset=0 force HI=0, LO=0, busy=0, counter=0 and latched operands=0, discarding any in-flight result.
REQ-025 SHALL drive start=0, stall=0 and E_HILOout=0 while reset=0 is asserted.

Configuration
REQ-026 SHALL support the macro MDU_MADD_EN: when defined, MADD/MADDU take 5 cycles and set {HI,LO} = {HI,LO} + signed/unsigned product (mod 2^64), using the HI/LO value at completion; when undefined, opcodes 9/10 are treated as NONE.

Structure
REQ-027 SHALL place the opcode constants, the latency constants (5, 10) and the counter width (4 bits) in the shared define package.
REQ-028 SHALL use exactly one sub-module, mdu_arith: a combinational block that takes the latched op and operands and returns 64-bit {hi,lo}, including the zero-divisor hold.

Verification
REQ-029 SHALL cover: MULT rs=0xFFFFFFFE, rt=3 -> busy for 5 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFFA.
REQ-030 SHALL cover: DIV rs=-7, rt=2 -> busy for 10 cycles, then LO=0xFFFFFFFD, HI=0xFFFFFFFF; DIVU 7/0 -> HI/LO unchanged after 10 cycles.
REQ-031 SHALL cover: MULT then D_isMD=1 (MFLO) -> stall=1 from the start cycle through the last busy cycle; the MFLO in E returns the new LO.
REQ-032 SHALL cover: MTHI 0x12345678 with busy=0 -> HI=0x12345678 the next cycle; MFHI -> E_HILOout=0x12345678.
REQ-033 SHALL cover: reset=0 asserted mid-divide (cycle 4 of 10) -> busy=0, HI=LO=0 immediately, and no late write after release.
REQ-034 SHALL cover, with MDU_MADD_EN: HI=0, LO=0xFFFFFFFF, MADDU 1*1 -> HI=1, LO=0; without the macro -> no busy, HI/LO unchanged.

Source files
------------

// File: rtl/mdu_ctrl_pkg.sv
// Shared definitions for the multiply/divide unit: opcodes, latencies, counter width.
// The optional MDU_MADD_EN macro adds MADD/MADDU to the set of multi-cycle ops.
package mdu_ctrl_pkg;

    typedef enum logic [3:0] {
        MD_NONE  = 4'd0,
        MD_MULT  = 4'd1,
        MD_MULTU = 4'd2,
        MD_DIV   = 4'd3,
        MD_DIVU  = 4'd4,
        MD_MFHI  = 4'd5,
        MD_MFLO  = 4'd6,
        MD_MTHI  = 4'd7,
        MD_MTLO  = 4'd8,
        MD_MADD  = 4'd9,
        MD_MADDU = 4'd10
    } md_op_e;

    localparam int CNT_W = 4;
    localparam logic [CNT_W-1:0] LAT_MUL = 4'd5;
    localparam logic [CNT_W-1:0] LAT_DIV = 4'd10;

    // Accumulating multiplies only exist as opcodes when the feature is built in
    function automatic logic is_mul_op(input logic [3:0] op);
`ifdef MDU_MADD_EN
        return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_MADD) || (op == MD_MADDU);
`else
        return (op == MD_MULT) || (op == MD_MULTU);
`endif
    endfunction

    function automatic logic is_div_op(input logic [3:0] op);
        return (op == MD_DIV) || (op == MD_DIVU);
    endfunction

    function automatic logic is_start_op(input logic [3:0] op);
        return is_mul_op(op) || is_div_op(op);
    endfunction

endpackage

// File: rtl/mdu_arith.sv
// Combinational result generator for the MDU: product, quotient/remainder, or held HI/LO.
// Accumulate variants (MADD/MADDU) are present only when MDU_MADD_EN is defined.
module mdu_arith
    import mdu_ctrl_pkg::*;
(
    input  logic [3:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [31:0] hi_in,
    input  logic [31:0] lo_in,
    output logic [63:0] result
);

    logic [63:0] prod_s;
    logic [63:0] prod_u;
    logic [31:0] quot_s;
    logic [31:0] rem_s;
    logic [31:0] quot_u;
    logic [31:0] rem_u;

    // Sign-extended operands give the signed product in the low 64 bits
    always_comb begin
        prod_s = {{32{a[31]}}, a} * {{32{b[31]}}, b};
        prod_u = {32'd0, a} * {32'd0, b};
        quot_s = '0;
        rem_s  = '0;
        quot_u = '0;
        rem_u  = '0;
        if (b == 32'd0) begin
            quot_s = '0;
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            quot_s = a;
            rem_s  = '0;
            quot_u = a / b;
            rem_u  = a % b;
        end else begin
            quot_s = $signed(a) / $signed(b);
            rem_s  = $signed(a) % $signed(b);
            quot_u = a / b;
            rem_u  = a % b;
        end
    end

    // A zero divisor falls through to the held HI/LO value
    always_comb begin
        result = {hi_in, lo_in};
        case (op)
            MD_MULT:  result = prod_s;
            MD_MULTU: result = prod_u;
            MD_DIV:   if (b != 32'd0) result = {rem_s, quot_s};
            MD_DIVU:  if (b != 32'd0) result = {rem_u, quot_u};
`ifdef MDU_MADD_EN
            MD_MADD:  result = {hi_in, lo_in} + prod_s;
            MD_MADDU: result = {hi_in, lo_in} + prod_u;
`endif
            default:  result = {hi_in, lo_in};
        endcase
    end

endmodule

// File: rtl/mdu_ctrl.sv
// Multi-cycle multiply/divide controller with HI/LO registers and pipeline stall generation.
// Define MDU_MADD_EN to enable the MADD/MADDU accumulate operations.
module mdu_ctrl
    import mdu_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  E_MDop,
    input  logic [31:0] E_rs,
    input  logic [31:0] E_rt,
    input  logic        D_isMD,
    output logic        start,
    output logic        busy,
    output logic        stall,
    output logic [31:0] E_HILOout,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    logic [3:0]       op_q;
    logic [31:0]      rs_q;
    logic [31:0]      rt_q;
    logic [CNT_W-1:0] cnt;
    logic [63:0]      arith_res;

    mdu_arith u_arith (
        .op     (op_q),
        .a      (rs_q),
        .b      (rt_q),
        .hi_in  (HI),
        .lo_in  (LO),
        .result (arith_res)
    );

    // Outputs are forced quiet while reset is held low
    always_comb begin
        start     = reset && !busy && is_start_op(E_MDop);
        stall     = reset && D_isMD && (start || busy);
        E_HILOout = '0;
        if (reset && E_MDop == MD_MFHI) E_HILOout = HI;
        if (reset && E_MDop == MD_MFLO) E_HILOout = LO;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            op_q <= '0;
            rs_q <= '0;
            rt_q <= '0;
            cnt  <= '0;
            busy <= 1'b0;
            HI   <= '0;
            LO   <= '0;
        end else if (start) begin
            op_q <= E_MDop;
            rs_q <= E_rs;
            rt_q <= E_rt;
            cnt  <= is_div_op(E_MDop) ? LAT_DIV : LAT_MUL;
            busy <= 1'b1;
        end else if (busy) begin
            // Completion owns HI/LO; any MT op in E is held off by the stall
            cnt <= cnt - CNT_W'(1);
            if (cnt == CNT_W'(1)) begin
                HI   <= arith_res[63:32];
                LO   <= arith_res[31:0];
                busy <= 1'b0;
            end
        end else if (E_MDop == MD_MTHI) begin
            HI <= E_rs;
        end else if (E_MDop == MD_MTLO) begin
            LO <= E_rs;
        end
    end

endmodule
